// File: rtl/decision_trail_if.sv
// rtl/decision_trail_if.sv - push, backtrack and status signals between the decider/BCP side and the trail
interface decision_trail_if #(
   parameter int VAR_BITS = 6
);
   logic                push_valid;
   logic                push_ready;
   logic [VAR_BITS-1:0] push_var;
   logic                push_val;
   logic                push_is_dec;
   logic [VAR_BITS-1:0] push_dec_idx;
   logic                conflict;
   logic                busy;
   logic                unassign_valid;
   logic [VAR_BITS-1:0] unassign_var;
   logic                bt_valid;
   logic [VAR_BITS-1:0] bt_var;
   logic                bt_val;
   logic [VAR_BITS-1:0] back_dec_idx;
   logic                unsat;
   logic [VAR_BITS:0]   count;
   logic [VAR_BITS:0]   level;

   modport master (
      output push_valid, push_var, push_val, push_is_dec, push_dec_idx, conflict,
      input  push_ready, busy, unassign_valid, unassign_var, bt_valid, bt_var,
             bt_val, back_dec_idx, unsat, count, level
   );

   modport slave (
      input  push_valid, push_var, push_val, push_is_dec, push_dec_idx, conflict,
      output push_ready, busy, unassign_valid, unassign_var, bt_valid, bt_var,
             bt_val, back_dec_idx, unsat, count, level
   );
endinterface

// File: rtl/decision_trail.sv
// rtl/decision_trail.sv - DPLL assignment trail: LIFO of decisions/implications with conflict unwind
module decision_trail #(
   parameter int MAX_VARS = 64,
   parameter int VAR_BITS = 6
) (
   input logic             clock,
   input logic             reset,
   decision_trail_if.slave tif
);
   typedef enum logic [1:0] {S_IDLE, S_POP, S_UNSAT} state_e;

   state_e              state_q, state_d;
   logic [VAR_BITS:0]   count_q, count_d;
   logic [VAR_BITS:0]   level_q, level_d;

   logic [VAR_BITS-1:0] ent_var     [MAX_VARS];
   logic                ent_val     [MAX_VARS];
   logic                ent_is_dec  [MAX_VARS];
   logic [VAR_BITS-1:0] ent_dec_idx [MAX_VARS];

   logic [VAR_BITS-1:0] top_idx;
   logic [VAR_BITS-1:0] push_idx;
   logic                wr_push, wr_flip;

   logic                push_ready_c, busy_c, unsat_c;
   logic                unassign_valid_c, bt_valid_c, bt_val_c;
   logic [VAR_BITS-1:0] unassign_var_c, bt_var_c, back_dec_idx_c;

   assign top_idx  = VAR_BITS'(count_q - (VAR_BITS+1)'(1));
   assign push_idx = VAR_BITS'(count_q);

   always_comb begin
      state_d          = state_q;
      count_d          = count_q;
      level_d          = level_q;
      wr_push          = 1'b0;
      wr_flip          = 1'b0;
      push_ready_c     = 1'b0;
      busy_c           = 1'b0;
      unsat_c          = 1'b0;
      unassign_valid_c = 1'b0;
      unassign_var_c   = '0;
      bt_valid_c       = 1'b0;
      bt_var_c         = '0;
      bt_val_c         = 1'b0;
      back_dec_idx_c   = '0;
      case (state_q)
         S_IDLE: begin
            push_ready_c = !tif.conflict && (count_q < (VAR_BITS+1)'(MAX_VARS));
            if (tif.conflict) begin
               state_d = S_POP;
            end else if (tif.push_valid && push_ready_c) begin
               wr_push = 1'b1;
               count_d = count_q + (VAR_BITS+1)'(1);
               level_d = level_q + {{VAR_BITS{1'b0}}, tif.push_is_dec};
            end
         end
         S_POP: begin
            busy_c = 1'b1;
            if (count_q == '0) begin
               // Trail exhausted with no decision left: flag unsat this cycle already
               unsat_c = 1'b1;
               state_d = S_UNSAT;
            end else if (!ent_is_dec[top_idx]) begin
               unassign_valid_c = 1'b1;
               unassign_var_c   = ent_var[top_idx];
               count_d          = count_q - (VAR_BITS+1)'(1);
            end else begin
               bt_valid_c     = 1'b1;
               bt_var_c       = ent_var[top_idx];
               bt_val_c       = ~ent_val[top_idx];
               back_dec_idx_c = ent_dec_idx[top_idx] + VAR_BITS'(1);
               wr_flip        = 1'b1;
               level_d        = level_q - (VAR_BITS+1)'(1);
               state_d        = S_IDLE;
            end
         end
         S_UNSAT: begin
            unsat_c = 1'b1;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         level_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         level_q <= level_d;
      end
   end

   // Entry storage carries no reset; only count_q decides which entries are live
   always_ff @(posedge clock) begin
      if (wr_push) begin
         ent_var[push_idx]     <= tif.push_var;
         ent_val[push_idx]     <= tif.push_val;
         ent_is_dec[push_idx]  <= tif.push_is_dec;
         ent_dec_idx[push_idx] <= tif.push_dec_idx;
      end
      if (wr_flip) begin
         ent_val[top_idx]    <= ~ent_val[top_idx];
         ent_is_dec[top_idx] <= 1'b0;
      end
   end

   // Outputs are forced low while reset is held, which also kills pulses mid-unwind
   assign tif.push_ready     = reset & push_ready_c;
   assign tif.busy           = reset & busy_c;
   assign tif.unsat          = reset & unsat_c;
   assign tif.unassign_valid = reset & unassign_valid_c;
   assign tif.unassign_var   = reset ? unassign_var_c : '0;
   assign tif.bt_valid       = reset & bt_valid_c;
   assign tif.bt_var         = reset ? bt_var_c : '0;
   assign tif.bt_val         = reset & bt_val_c;
   assign tif.back_dec_idx   = reset ? back_dec_idx_c : '0;
   assign tif.count          = reset ? count_q : '0;
   assign tif.level          = reset ? level_q : '0;
endmodule
